// File: rtl/fft_pingpong_ram.sv
// Two-bank ping-pong sample memory for the radix-2 FFT: dual read / dual write ports,
// stage sequencing and bank swapping. Optional macro: PINGPONG_COLLISION_DET_EN.
module fft_pingpong_ram #(
   parameter int BIT_WIDTH = 16,
   parameter int N         = 512,
   parameter int M         = 9
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   stage_done,
   input  logic                   we,
   input  logic [M-1:0]           wr_adr_a,
   input  logic [M-1:0]           wr_adr_b,
   input  logic [2*BIT_WIDTH-1:0] wd_a,
   input  logic [2*BIT_WIDTH-1:0] wd_b,
   input  logic                   re,
   input  logic [M-1:0]           rd_adr_a,
   input  logic [M-1:0]           rd_adr_b,
   output logic [2*BIT_WIDTH-1:0] rd_a,
   output logic [2*BIT_WIDTH-1:0] rd_b,
   output logic                   rd_valid,
   output logic                   bank_sel,
   output logic [M-1:0]           stage_cnt,
   output logic                   busy,
   output logic                   frame_done,
   output logic                   collision
);

   localparam int          W          = 2*BIT_WIDTH;
   localparam logic [M-1:0] LAST_STAGE = M'(M-1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t state, state_nx;
   logic   last_stage;
   logic   start_acc;
   logic   stage_acc;
   logic   wr_bank;

   // Both banks live in one array; the bank bit is the address MSB.
   logic [W-1:0] mem [0:2*N-1];

   assign last_stage = (stage_cnt == LAST_STAGE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = RUN;
         RUN:     if (stage_done && last_stage) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // IDLE writes always land in bank 0 (load path); RUN writes the bank not being read.
   always_comb begin
      busy      = (state == RUN);
      start_acc = (state == IDLE) && start;
      stage_acc = (state == RUN) && stage_done;
      wr_bank   = (state == RUN) ? ~bank_sel : 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bank_sel   <= 1'b0;
         stage_cnt  <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= stage_acc && last_stage;
         if (start_acc) begin
            bank_sel  <= 1'b0;
            stage_cnt <= '0;
         end else if (stage_acc) begin
            bank_sel <= ~bank_sel;
            if (!last_stage) stage_cnt <= stage_cnt + 1'b1;
         end
      end
   end

   // Port b is written after port a so it wins on an address tie; reset blocks writes.
   always_ff @(posedge clk or posedge reset) begin
      if (!reset && we) begin
         mem[{wr_bank, wr_adr_a}] <= wd_a;
         mem[{wr_bank, wr_adr_b}] <= wd_b;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_a     <= '0;
         rd_b     <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= re;
         if (re) begin
            rd_a <= mem[{bank_sel, rd_adr_a}];
            rd_b <= mem[{bank_sel, rd_adr_b}];
         end
      end
   end

`ifdef PINGPONG_COLLISION_DET_EN
   logic wr_tie;
   logic rd_hits_wr;
   logic coll_set;

   always_comb begin
      wr_tie     = we && (wr_adr_a == wr_adr_b);
      rd_hits_wr = re && we && (state == IDLE) && !bank_sel &&
                   ((rd_adr_a == wr_adr_a) || (rd_adr_a == wr_adr_b) ||
                    (rd_adr_b == wr_adr_a) || (rd_adr_b == wr_adr_b));
      coll_set   = wr_tie || rd_hits_wr;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)          collision <= 1'b0;
      else if (start_acc) collision <= 1'b0;
      else if (coll_set)  collision <= 1'b1;
   end
`else
   assign collision = 1'b0;
`endif

endmodule

// File: tb/tb_fft_pingpong_ram.sv
// Scoreboard bench for fft_pingpong_ram (N=8, M=3): directed plan scenarios followed by
// randomized traffic checked against a per-cycle behavioural model.
module tb_fft_pingpong_ram;

   localparam int BW = 16;
   localparam int NP = 8;
   localparam int MB = 3;
`ifdef PINGPONG_COLLISION_DET_EN
   localparam bit COLL_EN = 1'b1;
`else
   localparam bit COLL_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0, stage_done = 1'b0, we = 1'b0, re = 1'b0;
   logic [MB-1:0] wr_adr_a = '0, wr_adr_b = '0, rd_adr_a = '0, rd_adr_b = '0;
   logic [31:0]   wd_a = '0, wd_b = '0;
   logic [31:0]   rd_a, rd_b;
   logic          rd_valid, bank_sel, busy, frame_done, collision;
   logic [MB-1:0] stage_cnt;

   fft_pingpong_ram #(.BIT_WIDTH(BW), .N(NP), .M(MB)) dut (
      .clk(clk), .reset(reset), .start(start), .stage_done(stage_done), .we(we),
      .wr_adr_a(wr_adr_a), .wr_adr_b(wr_adr_b), .wd_a(wd_a), .wd_b(wd_b),
      .re(re), .rd_adr_a(rd_adr_a), .rd_adr_b(rd_adr_b), .rd_a(rd_a), .rd_b(rd_b),
      .rd_valid(rd_valid), .bank_sel(bank_sel), .stage_cnt(stage_cnt), .busy(busy),
      .frame_done(frame_done), .collision(collision)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      bit          ka;
      bit          kb;
   } rd_t;

   rd_t sb[$];
   int  total = 0;
   int  bad = 0;
   int  fd_cnt = 0;

   // Reference model: memory contents with "known" flags, plus the control view.
   logic [31:0] mdl [2][NP];
   bit          kn  [2][NP];
   int          m_run, m_bank, m_stage;
   bit          m_coll, fd_exp, rv_exp, m_lastre, m_rka, m_rkb;
   logic [31:0] m_rda, m_rdb;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_run = 0; m_bank = 0; m_stage = 0; m_coll = 0;
      fd_exp = 0; rv_exp = 0; m_lastre = 0;
      m_rda = '0; m_rdb = '0; m_rka = 1; m_rkb = 1;
      sb.delete();
   endtask

   task automatic model_edge();
      rd_t e;
      int  wbk;
      bit  cs;
      if (reset) begin
         model_reset();
         return;
      end
      m_lastre = re;
      rv_exp   = re;
      fd_exp   = 0;
      if (re) begin
         e.a  = mdl[m_bank][rd_adr_a];
         e.ka = kn[m_bank][rd_adr_a];
         e.b  = mdl[m_bank][rd_adr_b];
         e.kb = kn[m_bank][rd_adr_b];
         sb.push_back(e);
         m_rda = e.a; m_rka = e.ka;
         m_rdb = e.b; m_rkb = e.kb;
      end
      wbk = (m_run != 0) ? 1 - m_bank : 0;
      cs  = (we && wr_adr_a == wr_adr_b) ||
            (re && we && m_run == 0 && m_bank == 0 &&
             (rd_adr_a == wr_adr_a || rd_adr_a == wr_adr_b ||
              rd_adr_b == wr_adr_a || rd_adr_b == wr_adr_b));
      if (we) begin
         mdl[wbk][wr_adr_a] = wd_a; kn[wbk][wr_adr_a] = 1;
         mdl[wbk][wr_adr_b] = wd_b; kn[wbk][wr_adr_b] = 1;
      end
      if (m_run == 0 && start) begin
         m_run = 1; m_bank = 0; m_stage = 0; m_coll = 0;
      end else begin
         if (cs && COLL_EN) m_coll = 1;
         if (m_run != 0 && stage_done) begin
            m_bank = 1 - m_bank;
            if (m_stage == MB - 1) begin
               m_run  = 0;
               fd_exp = 1;
            end else begin
               m_stage++;
            end
         end
      end
   endtask

   task automatic check_ctrl();
      chk("bank_sel",   32'(bank_sel),   32'(m_bank));
      chk("stage_cnt",  32'(stage_cnt),  32'(m_stage));
      chk("busy",       32'(busy),       32'(m_run));
      chk("frame_done", 32'(frame_done), 32'(fd_exp));
      chk("rd_valid",   32'(rd_valid),   32'(rv_exp));
      chk("collision",  32'(collision),  32'(m_coll));
      if (!m_lastre && m_rka) chk("rd_a_hold", rd_a, m_rda);
      if (!m_lastre && m_rkb) chk("rd_b_hold", rd_b, m_rdb);
      if (frame_done) fd_cnt++;
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      check_ctrl();
   endtask

   task automatic clr();
      start = 0; stage_done = 0; we = 0; re = 0;
   endtask

   // Async reset mid-cycle, with a write attempt that must not land.
   task automatic do_reset();
      #2;
      reset = 1; we = 1; wr_adr_a = 3'd2; wr_adr_b = 3'd2;
      wd_a = 32'hDEAD_BEEF; wd_b = 32'hDEAD_BEEF;
      #1;
      model_reset();
      chk("rst_rd_a",       rd_a, 32'h0);
      chk("rst_rd_b",       rd_b, 32'h0);
      chk("rst_rd_valid",   32'(rd_valid),   32'h0);
      chk("rst_bank_sel",   32'(bank_sel),   32'h0);
      chk("rst_stage_cnt",  32'(stage_cnt),  32'h0);
      chk("rst_busy",       32'(busy),       32'h0);
      chk("rst_frame_done", 32'(frame_done), 32'h0);
      chk("rst_collision",  32'(collision),  32'h0);
      tick();
      reset = 0;
      clr();
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents read data.
   always @(negedge clk) begin
      rd_t e;
      if (!reset && rd_valid) begin
         if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL rd_unexpected: got rd_valid=1 want no pending read");
         end else begin
            e = sb.pop_front();
            if (e.ka) chk("sb_rd_a", rd_a, e.a);
            if (e.kb) chk("sb_rd_b", rd_b, e.b);
         end
      end
   end

   initial begin
      for (int b = 0; b < 2; b++)
         for (int k = 0; k < NP; k++) begin
            mdl[b][k] = '0; kn[b][k] = 0;
         end
      model_reset();
      do_reset();

      // Load / readback
      for (int k = 0; k < NP; k += 2) begin
         we = 1; wr_adr_a = 3'(k); wr_adr_b = 3'(k + 1);
         wd_a = 32'h100 + 32'(k); wd_b = 32'h100 + 32'(k + 1);
         tick(); clr();
      end
      re = 1; rd_adr_a = 3'd0; rd_adr_b = 3'd7;
      tick(); clr();
      chk("load_rd_a", rd_a, 32'h0000_0100);
      chk("load_rd_b", rd_b, 32'h0000_0107);
      chk("load_valid", 32'(rd_valid), 32'h1);
      tick();

      // Same-address write: port b wins
      we = 1; wr_adr_a = 3'd5; wr_adr_b = 3'd5;
      wd_a = 32'h1111_1111; wd_b = 32'h2222_2222;
      tick(); clr();
      re = 1; rd_adr_a = 3'd5; rd_adr_b = 3'd5;
      tick(); clr();
      chk("same_adr_rd", rd_a, 32'h2222_2222);
      chk("same_adr_coll", 32'(collision), 32'(COLL_EN));
      we = 1; wr_adr_a = 3'd5; wr_adr_b = 3'd4;
      wd_a = 32'h105; wd_b = 32'h104;
      tick(); clr();

      // stage_done in IDLE is ignored
      stage_done = 1; tick(); clr();
      chk("idle_stage_done", 32'(stage_cnt), 32'h0);

      // Ping-pong
      start = 1; tick(); clr();
      we = 1; wr_adr_a = 3'd2; wr_adr_b = 3'd6;
      wd_a = 32'hAAAA_5555; wd_b = $urandom;
      re = 1; rd_adr_a = 3'd2; rd_adr_b = 3'd2;
      tick(); clr();
      chk("pp_old", rd_a, 32'h0000_0102);
      stage_done = 1; tick(); clr();
      re = 1; rd_adr_a = 3'd2; rd_adr_b = 3'd2;
      tick(); clr();
      chk("pp_new", rd_a, 32'hAAAA_5555);
      chk("pp_bank", 32'(bank_sel), 32'h1);
      start = 1; tick(); clr();
      chk("run_start_ignored", 32'(stage_cnt), 32'h1);
      stage_done = 1; tick(); clr();
      stage_done = 1; tick(); clr();
      tick();

      // Frame sequencing
      start = 1; tick(); clr();
      fd_cnt = 0;
      for (int s = 0; s < MB; s++) begin
         chk("seq_stage", 32'(stage_cnt), 32'(s));
         stage_done = 1; tick(); clr();
         tick(); tick(); tick();
      end
      chk("seq_fd_count", 32'(fd_cnt), 32'h1);
      chk("seq_busy", 32'(busy), 32'h0);
      chk("seq_bank", 32'(bank_sel), 32'h1);

      // Reset during stage 1, then a full frame
      start = 1; tick(); clr();
      stage_done = 1; tick(); clr();
      tick();
      do_reset();
      start = 1; tick(); clr();
      fd_cnt = 0;
      for (int s = 0; s < MB; s++) begin
         stage_done = 1; tick(); clr();
         tick();
      end
      chk("post_rst_fd_count", 32'(fd_cnt), 32'h1);

      // Randomized traffic
      for (int i = 0; i < 800; i++) begin
         start      = ($urandom_range(0, 15) == 0);
         stage_done = ($urandom_range(0, 3) == 0);
         we         = 1'($urandom_range(0, 1));
         re         = 1'($urandom_range(0, 1));
         wr_adr_a   = 3'($urandom_range(0, 7));
         wr_adr_b   = 3'($urandom_range(0, 7));
         rd_adr_a   = 3'($urandom_range(0, 7));
         rd_adr_b   = 3'($urandom_range(0, 7));
         wd_a       = $urandom;
         wd_b       = $urandom;
         tick();
         if ($urandom_range(0, 199) == 0) do_reset();
      end
      clr();
      tick(); tick();
      chk("sb_empty", 32'(sb.size()), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fft_pingpong_ram.md
# fft_pingpong_ram

Parametrised two-bank ping-pong buffer memory for the radix-2 FFT datapath. It holds N complex samples packed as {Re, Im} per bank. The butterfly reads two words per cycle from one bank and writes two words per cycle to the other bank. It tracks the stage count, swaps banks on each stage boundary, signals frame completion, and exposes the final result bank for readout. It sits between the sample loader/AGU and the butterfly unit, replacing the unregistered single-bank RAM with a controlled, registered-read successor.

## Interface
- BIT_WIDTH, 16: width of each of Re and Im; word width is 2*BIT_WIDTH.
- N, 512: points per frame; words per bank; must be a power of two, N >= 4.
- M, 9: log2(N); address width and number of FFT stages.

- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a frame (accepted only in IDLE).
- stage_done  in  1  one-cycle pulse from the AGU; ends the current stage (accepted only in RUN).
- we  in  1  write enable for both write ports.
- wr_adr_a, wr_adr_b  in  M  write addresses.
- wd_a, wd_b  in  2*BIT_WIDTH  write data {Re, Im}.
- re  in  1  read enable for both read ports.
- rd_adr_a, rd_adr_b  in  M  read addresses.
- rd_a, rd_b  out  2*BIT_WIDTH  registered read data.
- rd_valid  out  1  rd_a/rd_b hold data for the read issued in the previous cycle.
- bank_sel  out  1  bank currently read (the other bank is written in RUN).
- stage_cnt  out  M  stage index 0..M-1 (width M suffices).
- busy  out  1  high in RUN.
- frame_done  out  1  one-cycle pulse when the final stage completes.
- collision  out  1  sticky write-collision flag (see Configuration).

## Operation
- Two banks of N words each. Memory contents are not reset.
- States:
  - IDLE: writes go to bank 0, which is the load path. Reads come from bank bank_sel, which is the result path.
  - RUN: reads come from bank bank_sel; writes go to bank ~bank_sel.
- IDLE → RUN on start. Same edge: bank_sel <= 0, stage_cnt <= 0, busy <= 1.
- RUN on stage_done:
  - bank_sel toggles.
  - If stage_cnt == M-1: go to IDLE, busy <= 0, frame_done pulses one cycle, stage_cnt holds M-1.
  - Otherwise: stage_cnt increments.
- After a frame, bank_sel points at the bank written last, so an IDLE readout returns the FFT result (bank 1 if M is odd, bank 0 if M is even).
- start while in RUN: ignored. stage_done while in IDLE: ignored.
- Writes on the same edge as a stage_done or start use the bank mapping in force before that edge.
- Same bank read and written in the same cycle (IDLE only, bank_sel=0): the read returns old data (read-before-write).
- we with wr_adr_a == wr_adr_b: port b data is stored.

## Timing
- Read latency is 1 cycle. rd_a, rd_b and rd_valid register on the edge after re is sampled. When re=0, rd_a and rd_b hold their previous values and rd_valid = 0.
- Read-bank selection uses bank_sel as sampled on the edge that captures the read.
- Write takes effect on the sampling edge and is visible to a read issued on the next cycle.
- frame_done is asserted in the cycle following the final stage_done edge. busy is deasserted in that same cycle.
- Reset values: rd_a = rd_b = 0, rd_valid = 0, bank_sel = 0, stage_cnt = 0, busy = 0, frame_done = 0, collision = 0, state = IDLE.
- Reset asserted mid-frame aborts the frame immediately. Bank contents are undefined for use, but no write occurs while reset is high.

## Configuration
- PINGPONG_COLLISION_DET_EN defined: collision sets when we=1 and wr_adr_a == wr_adr_b. It also sets when re=1 and either read address targets the bank being written in IDLE at an address written that cycle. It clears only on reset or start.
- PINGPONG_COLLISION_DET_EN undefined: collision is tied to 0 and no comparison logic is built.

## Test plan
All scenarios use N=8, M=3, BIT_WIDTH=16.
- Load/readback: in IDLE, write addr k = 32'h0000_0100+k for k=0..7, then read addr 0 and 7 → the following cycle gives rd_a=32'h0000_0100, rd_b=32'h0000_0107, rd_valid=1.
- Ping-pong: start, then in RUN write addr 2 = 32'hAAAA_5555 and read addr 2 → rd returns the bank-0 value 32'h0000_0102. Pulse stage_done, then read addr 2 → 32'hAAAA_5555 and bank_sel=1.
- Frame sequencing: start, then three stage_done pulses spaced 4 cycles apart → stage_cnt goes 0,1,2; frame_done pulses once after the third pulse; busy=0; bank_sel=1.
- Ignored controls: stage_done in IDLE leaves stage_cnt=0 and bank_sel unchanged; start during RUN leaves stage_cnt unchanged.
- Same-address write: we with wr_adr_a=wr_adr_b=5, wd_a=32'h1111_1111, wd_b=32'h2222_2222 → read addr 5 gives 32'h2222_2222. collision=1 with the macro defined, 0 without.
- Reset mid-frame: assert reset during stage 1 → all outputs match their reset values in the same cycle; a subsequent start runs a full frame normally.
